// File: rtl/sram_bus_ctrl_pkg.sv
// Shared types and defaults for the SRAM bus controller.
// Holds the FSM state encoding, the request-source tag and parameter defaults.
// No logic lives here; the top and the wait timer import it.
package sram_bus_ctrl_pkg;

    localparam int DEF_ADDR_W   = 20;
    localparam int DEF_RD_WAIT  = 1;
    localparam int DEF_WR_PULSE = 2;
    localparam int TMR_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WS   = 3'd2,
        ST_WP   = 3'd3,
        ST_WH   = 3'd4,
        ST_ACK  = 3'd5
    } state_e;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // Timer reload value, truncated to the counter width.
    function automatic logic [TMR_W-1:0] tmr_val(input int cycles);
        return TMR_W'(cycles);
    endfunction

endpackage

// File: rtl/sram_bus_ctrl_if.sv
// CPU-side bus bundle: instruction fetch port and load/store port.
// Purely wiring; suffixes are named from the controller's point of view.
// Requests are held by the CPU until the matching one-cycle ack.
interface sram_bus_ctrl_if;

    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;

    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ack_o;

    // CPU side
    modport master (
        output if_ce_i, if_addr_i,
        input  if_data_o, if_ack_o,
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, mem_ack_o
    );

    // Controller side
    modport slave (
        input  if_ce_i, if_addr_i,
        output if_data_o, if_ack_o,
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, mem_ack_o
    );

endinterface

// File: rtl/sram_wait_timer.sv
// Small down-counter timing the read-wait and write-pulse phases.
// Load takes effect on the next edge; done_o is high while the count is zero.
// No backpressure: counts down every cycle it is not being loaded.
module sram_wait_timer
    import sram_bus_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             done_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Reload has priority; otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bus_ctrl.sv
// Arbitrates fetch and load/store ports onto one async SRAM with registered strobes.
// Read ack RD_WAIT+2 cycles after accept, write ack WR_PULSE+3; one access per latency+1.
// stall_o holds the CPU while any request is waiting; only IDLE accepts, load/store first.
module sram_bus_ctrl
    import sram_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_WAIT  = DEF_RD_WAIT,
    parameter int WR_PULSE = DEF_WR_PULSE
) (
    input  logic              clk,
    input  logic              rst,
    sram_bus_ctrl_if.slave    cpu,
    output logic              stall_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [31:0]       ram_data_i,
    output logic [31:0]       ram_data_o,
    output logic              ram_data_oe_o,
    output logic [3:0]        ram_be_n_o,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o
);

    state_e            state_q;
    src_e              src_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_n_q;
    logic              ce_n_q;
    logic              oe_n_q;
    logic              we_n_q;
    logic              data_oe_q;
    logic              if_ack_q;
    logic              mem_ack_q;
    logic [31:0]       if_data_q;
    logic [31:0]       mem_data_q;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_done;

    // Byte-lane bits and address bits above the SRAM window alias away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu.if_addr_i[31:ADDR_W+2], cpu.if_addr_i[1:0],
                                cpu.mem_addr_i[31:ADDR_W+2], cpu.mem_addr_i[1:0]};

    // Reload the timer while in the state just before each timed phase,
    // so it holds the full count on entry to RD or WP.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                tmr_load     = 1'b1;
                tmr_load_val = tmr_val(RD_WAIT);
            end
            ST_WS: begin
                tmr_load     = 1'b1;
                tmr_load_val = tmr_val(WR_PULSE - 1);
            end
            default: ;
        endcase
    end

    sram_wait_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done)
    );

    // Access sequencer: every strobe, ack and data register is set on the
    // transition into the state that needs it, so all pins come from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_IF;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            be_n_q     <= 4'hF;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            data_oe_q  <= 1'b0;
            if_ack_q   <= 1'b0;
            mem_ack_q  <= 1'b0;
            if_data_q  <= '0;
            mem_data_q <= '0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu.mem_ce_i) begin
                        src_q      <= SRC_MEM;
                        ram_addr_q <= cpu.mem_addr_i[ADDR_W+1:2];
                        ce_n_q     <= 1'b0;
                        if (cpu.mem_we_i) begin
                            state_q   <= ST_WS;
                            wdata_q   <= cpu.mem_data_i;
                            be_n_q    <= ~cpu.mem_sel_i;
                            data_oe_q <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            oe_n_q  <= 1'b0;
                            be_n_q  <= 4'h0;
                        end
                    end else if (cpu.if_ce_i) begin
                        state_q    <= ST_RD;
                        src_q      <= SRC_IF;
                        ram_addr_q <= cpu.if_addr_i[ADDR_W+1:2];
                        ce_n_q     <= 1'b0;
                        oe_n_q     <= 1'b0;
                        be_n_q     <= 4'h0;
                    end
                end
                ST_RD: begin
                    if (tmr_done) begin
                        state_q <= ST_ACK;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        be_n_q  <= 4'hF;
                        if (src_q == SRC_MEM) begin
                            mem_data_q <= ram_data_i;
                            mem_ack_q  <= 1'b1;
                        end else begin
                            if_data_q <= ram_data_i;
                            if_ack_q  <= 1'b1;
                        end
                    end
                end
                ST_WS: begin
                    state_q <= ST_WP;
                    we_n_q  <= 1'b0;
                end
                ST_WP: begin
                    if (tmr_done) begin
                        state_q <= ST_WH;
                        we_n_q  <= 1'b1;
                    end
                end
                ST_WH: begin
                    state_q   <= ST_ACK;
                    ce_n_q    <= 1'b1;
                    be_n_q    <= 4'hF;
                    data_oe_q <= 1'b0;
                    // Only the load/store port can write.
                    mem_ack_q <= 1'b1;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu.if_data_o  = if_data_q;
    assign cpu.if_ack_o   = if_ack_q;
    assign cpu.mem_data_o = mem_data_q;
    assign cpu.mem_ack_o  = mem_ack_q;

    assign stall_o = (cpu.if_ce_i & ~if_ack_q) | (cpu.mem_ce_i & ~mem_ack_q);

    assign ram_addr_o    = ram_addr_q;
    assign ram_data_o    = wdata_q;
    assign ram_data_oe_o = data_oe_q;
    assign ram_be_n_o    = be_n_q;
    assign ram_ce_n_o    = ce_n_q;
    assign ram_oe_n_o    = oe_n_q;
    assign ram_we_n_o    = we_n_q;

endmodule
